// File: rtl/regbank_pkg.sv
// Shared definitions for the sweep-cleared register bank: the sweep FSM state
// encoding, the all-zero data bit the sweep writes, and the address-width helper.
package regbank_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regbank_state_e;

    // Replicated to the data width wherever an entry is cleared or a read is blanked.
    localparam logic REGBANK_ZERO = 1'b0;

    // Address bits needed to index DEPTH entries (never less than one bit).
    function automatic int regbank_aw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regbank_sweep_if.sv
// Bus bundle of the register bank: one write port, two read ports, and the
// clear request/busy pair. The master drives addresses, data and clr; the
// bank (slave) returns read data and busy.
interface regbank_sweep_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             we3;
    logic [AW-1:0]    wa3;
    logic [WIDTH-1:0] wd3;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic             clr;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             busy;

    modport master (
        output we3, wa3, wd3, ra1, ra2, clr,
        input  rd1, rd2, busy
    );

    modport slave (
        input  we3, wa3, wd3, ra1, ra2, clr,
        output rd1, rd2, busy
    );
endinterface

// File: rtl/regbank_clr_fsm.sv
// Clear-sweep controller. Owns the IDLE/CLEAR state, the sweep counter and
// the registered busy flag, and hands the array one zero-write per cycle
// while a sweep runs. A clr seen during a sweep restarts it from entry 0.
module regbank_clr_fsm
    import regbank_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = regbank_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    output logic          o_busy,
    output logic          o_sweep_we,
    output logic [AW-1:0] o_sweep_addr
);
    localparam logic [0:0]    S_IDLE    = IDLE;
    localparam logic [0:0]    S_CLEAR   = CLEAR;
    localparam int            DEPTH_M1  = DEPTH - 1;
    localparam logic [AW-1:0] LAST_ADDR = DEPTH_M1[AW-1:0];

    logic [0:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;

    // State, sweep counter and busy advance together on each rising edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (i_clr) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST_ADDR) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                default: begin
                    if (i_clr) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // A restarting clr edge writes nothing; the entry at cnt 0 is written next edge.
    assign o_sweep_we   = (r_state == S_CLEAR) && !i_clr && !reset;
    assign o_sweep_addr = r_cnt;
    assign o_busy       = r_busy;

endmodule

// File: rtl/regbank_sweep.sv
// Two-read/one-write register bank with a self-clearing sweep.
// WIDTH x DEPTH storage, optional hardwired-zero register 0 (ZERO_REG), and
// combinational reads that return 0 during reset and while a sweep runs.
// Optional build macro REGBANK_SWEEP_BYPASS_EN: in IDLE a legal write is
// forwarded to a read port addressing the same entry in the same cycle.
module regbank_sweep
    import regbank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    regbank_sweep_if.slave  bus
);
    localparam int         AW      = regbank_aw(DEPTH);
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic             w_busy;
    logic             w_sweep_we;
    logic [AW-1:0]    w_sweep_addr;
    logic             w_wa_valid;
    logic             w_wa_zero;
    logic             w_user_we;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    logic [WIDTH-1:0] r_mem [DEPTH];

    regbank_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (bus.clr),
        .o_busy       (w_busy),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr)
    );

    // A user write lands only in IDLE, without a competing clr, inside the
    // array, and never on a hardwired-zero register 0.
    assign w_wa_valid = ({1'b0, bus.wa3} < DEPTH_W);
    assign w_wa_zero  = (ZERO_REG != 0) && (bus.wa3 == '0);
    assign w_user_we  = !reset && !w_busy && bus.we3 && !bus.clr && w_wa_valid && !w_wa_zero;

    // Storage: the sweep owns the write port while it runs, otherwise we3 does.
    // NOTE: the array has no reset branch; its contents are established by the
    // sweep, which keeps it mappable onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[w_sweep_addr] <= {WIDTH{REGBANK_ZERO}};
        end else if (w_user_we) begin
            r_mem[bus.wa3] <= bus.wd3;
        end
    end

    // Stored value seen by a read port, blanked during reset/sweep, for
    // out-of-range addresses, and for a hardwired-zero register 0.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] v;
        v = {WIDTH{REGBANK_ZERO}};
        if (!reset && !w_busy && ({1'b0, ra} < DEPTH_W) &&
            !((ZERO_REG != 0) && (ra == '0))) begin
            v = r_mem[ra];
        end
        return v;
    endfunction

    // Read port 1, with optional same-cycle forwarding of the accepted write.
    // NOTE: every branch-assigned combinational output gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rd1 = read_port(bus.ra1);
`ifdef REGBANK_SWEEP_BYPASS_EN
        if (w_user_we && (bus.ra1 == bus.wa3)) begin
            w_rd1 = bus.wd3;
        end
`endif
    end

    // Read port 2, same rules as port 1.
    always_comb begin
        w_rd2 = read_port(bus.ra2);
`ifdef REGBANK_SWEEP_BYPASS_EN
        if (w_user_we && (bus.ra2 == bus.wa3)) begin
            w_rd2 = bus.wd3;
        end
`endif
    end

    assign bus.rd1  = w_rd1;
    assign bus.rd2  = w_rd2;
    assign bus.busy = w_busy;

endmodule

// File: doc/regbank_sweep.md
# regbank_sweep

Parametrised successor to the processor's two-read/one-write register file: configurable data width and depth, optional hardwired-zero register 0, and a hardware clear sweep. After reset, or on request, the block zeroes every entry itself, one entry per cycle, and raises `busy` while it does so. It replaces the fixed 16×8 bank in the datapath. Contents are defined by the sweep, not by a preload file.

## Interface
Parameters:
- `WIDTH`, 8: data width in bits.
- `DEPTH`, 16: number of registers. Must be ≥2.
- `ZERO_REG`, 1: when 1, register 0 always reads 0 and writes to it are dropped.

Derived:
- `AW` = $clog2(DEPTH).

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `we3`  in  1: write enable.
- `wa3`  in  AW: write address.
- `wd3`  in  WIDTH: write data.
- `ra1`, `ra2`  in  AW: read addresses.
- `clr`  in  1: synchronous clear request, sampled on the rising edge.
- `rd1`, `rd2`  out  WIDTH: combinational read data.
- `busy`  out  1: high while a clear sweep is in progress.

## Operation
FSM states: `IDLE` and `CLEAR`. Sweep counter `cnt` is AW bits wide.

Reset (asserted):
- state = `CLEAR`, `cnt` = 0, `busy` = 1.
- `rd1`/`rd2` = 0 while reset is asserted.
- The storage array itself is not reset.

`CLEAR` state, on each rising edge:
- Write `mem[cnt]` = 0 and increment `cnt`.
- When `cnt` == DEPTH-1: go to `IDLE` and set `busy` = 0.
- `clr` asserted in this state restarts the sweep: `cnt` = 0, and the current edge writes no entry.
- `we3` is ignored; user writes are dropped, not queued.
- `rd1`/`rd2` read 0 regardless of address.

`IDLE` state, on each rising edge:
- `we3` = 1: `mem[wa3]` = `wd3`, except the write is dropped if `ZERO_REG` = 1 and `wa3` = 0.
- `clr` = 1: go to `CLEAR` with `cnt` = 0 and `busy` = 1. `clr` takes priority over a simultaneous `we3`, so that write is dropped.

Reads in `IDLE`:
- `rdN` = `mem[raN]`, or 0 when `ZERO_REG` = 1 and `raN` = 0.
- Both ports may read the same address.

Address range:
- Addresses ≥ DEPTH (possible when DEPTH is not a power of 2) are invalid.
- Writes to them are dropped; reads of them return 0.

Reset mid-sweep: the sweep restarts from `cnt` = 0.

## Timing
- Read path is purely combinational: zero latency from `raN` to `rdN`.
- Write is visible on `rdN` from the edge after which it is captured (one-cycle write-to-read latency), unless bypass is compiled in.
- Sweep length:
  - After reset deasserts, `busy` falls on the DEPTH-th rising edge. Every entry is 0 from that edge on.
  - A `clr` sampled on edge k gives `busy` = 1 after edge k and `busy` = 0 after edge k+DEPTH.
- `busy` is a registered output: no combinational path from `clr` to `busy`.

## Configuration
Macro: `REGBANK_SWEEP_BYPASS_EN`.
- Defined, in `IDLE`: when `we3` = 1, `raN` == `wa3` and the write is legal, `rdN` = `wd3` in the same cycle (write-through forwarding). A write dropped because of register 0 or `clr` priority is not forwarded.
- Not defined: no forwarding; the old value is read until the next edge.
- `CLEAR` behaviour is identical in both builds.

## Structure
Shared package `regbank_pkg`:
- State enum {`IDLE`, `CLEAR`}.
- Address-width helper function.
- `REGBANK_ZERO` data constant.

Sub-module `regbank_clr_fsm`:
- Owns the state, `cnt` and `busy`.
- Outputs the sweep write enable and sweep address to the array.

Top level contains:
- The storage array.
- Write arbitration between the sweep and `we3`.
- Read muxing and the optional bypass.

## Test plan
- **Reset sweep.** Pulse `reset`, then release it. Expect `busy` = 1 for exactly 16 edges, then 0. Then read all 16 addresses: all return 0x00.
- **Write/read.** In `IDLE`, write 0xA5 to r3 and 0x3C to r15. Set `ra1` = 3, `ra2` = 15. Next cycle expect `rd1` = 0xA5, `rd2` = 0x3C.
- **Zero register.** `ZERO_REG` = 1: write 0xFF to r0, then read r0. Expect `rd1` = 0x00. Repeat with `ZERO_REG` = 0: expect 0xFF.
- **clr/we3 collision.**
  - Assert `clr` and `we3` (r5 = 0x11) on the same edge. Expect `busy` = 1 and r5 = 0 after the sweep.
  - A second `clr` 5 edges into the sweep extends `busy` to 5+16 edges.
- **Bypass.** With `REGBANK_SWEEP_BYPASS_EN`: `we3` = 1, `wa3` = 7, `wd3` = 0x42, `ra1` = 7. Expect `rd1` = 0x42 in the same cycle. Without the macro: expect the old value, then 0x42 after the edge.
- **Non-power-of-2 depth.** DEPTH = 12, WIDTH = 16:
  - `busy` lasts 12 edges.
  - A write to address 13 is dropped and a read of address 13 returns 0.
  - A reset asserted mid-sweep restarts the full 12-edge sweep.
